// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : display_arbiter
// Description : Round-robin arbiter between a CPU port and a debug source for
//               a 4-digit seven-segment monitor; each grant is held on the
//               display for HOLD_CYCLES clocks before another can be taken.
// Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [15:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        busy
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_HOLD    = 2'd1;
    localparam logic [1:0]  S_OPEN    = 2'd2;

    localparam logic [1:0]  SRC_NONE  = 2'b00;
    localparam logic [1:0]  SRC_A     = 2'b01;
    localparam logic [1:0]  SRC_B     = 2'b10;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_b_q, last_b_d;
    logic [15:0] disp_data_q, disp_data_d;
    logic [1:0]  disp_src_q, disp_src_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;

    logic        w_accept;
    logic        w_win_a;
    logic        w_win_b;

    // On a tie, A wins unless A was the most recent grant.
    assign w_accept = (state_q != S_HOLD) && (req_a || req_b);
    assign w_win_a  = req_a && (!req_b || last_b_q);
    assign w_win_b  = req_b && !w_win_a;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'h0000;
            last_b_q    <= 1'b1;
            disp_data_q <= 16'h0000;
            disp_src_q  <= SRC_NONE;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            disp_data_q <= disp_data_d;
            disp_src_q  <= disp_src_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
        end
    end

    // Next-state and hold timer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_OPEN: begin
                if (w_accept) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == 16'h0000) begin
                    state_d = S_OPEN;
                end else begin
                    cnt_d = cnt_q - 16'h0001;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'h0000;
            end
        endcase
    end

    // Grant pulses, display latch and round-robin record
    always_comb begin
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        disp_data_d = disp_data_q;
        disp_src_d  = disp_src_q;
        last_b_d    = last_b_q;
        if (w_accept) begin
            if (w_win_a) begin
                gnt_a_d     = 1'b1;
                disp_data_d = data_a;
                disp_src_d  = SRC_A;
                last_b_d    = 1'b0;
            end else if (w_win_b) begin
                gnt_b_d     = 1'b1;
                disp_data_d = data_b;
                disp_src_d  = SRC_B;
                last_b_d    = 1'b1;
            end
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign disp_data = disp_data_q;
    assign disp_src  = disp_src_q;
    assign busy      = (state_q == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_arbiter
// Description : Self-checking bench; two arbiters (HOLD_CYCLES 4 and 1) run
//               against a timer/queue-level model plus literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int HV [2] = '{4, 1};

    logic             clk;
    logic             reset;
    logic [1:0]       req_a, req_b;
    logic [1:0][15:0] data_a, data_b;
    logic [1:0]       gnt_a, gnt_b, busy;
    logic [1:0][15:0] disp_data;
    logic [1:0][1:0]  disp_src;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining busy cycles, last winner, displayed value.
    logic [1:0][15:0] m_disp;
    logic [1:0][1:0]  m_src;
    logic [1:0]       m_last_b, m_ga, m_gb;
    int               m_left [2];

    display_arbiter #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_a(req_a[0]), .data_a(data_a[0]),
        .req_b(req_b[0]), .data_b(data_b[0]),
        .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]),
        .disp_data(disp_data[0]), .disp_src(disp_src[0]), .busy(busy[0])
    );

    display_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_a(req_a[1]), .data_a(data_a[1]),
        .req_b(req_b[1]), .data_b(data_b[1]),
        .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]),
        .disp_data(disp_data[1]), .disp_src(disp_src[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic pick_b(logic ra, logic rb, logic last_b);
        return rb && (!ra || !last_b);
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_disp[i]   <= 16'h0000;
                m_src[i]    <= 2'b00;
                m_last_b[i] <= 1'b1;
                m_left[i]   <= 0;
                m_ga[i]     <= 1'b0;
                m_gb[i]     <= 1'b0;
            end else begin
                m_ga[i] <= 1'b0;
                m_gb[i] <= 1'b0;
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                end else if (req_a[i] || req_b[i]) begin
                    m_left[i] <= HV[i];
                    if (pick_b(req_a[i], req_b[i], m_last_b[i])) begin
                        m_gb[i] <= 1'b1; m_disp[i] <= data_b[i];
                        m_src[i] <= 2'b10; m_last_b[i] <= 1'b1;
                    end else begin
                        m_ga[i] <= 1'b1; m_disp[i] <= data_a[i];
                        m_src[i] <= 2'b01; m_last_b[i] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at %0t: actual=%h expected=%h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("gnt_a", i, 32'(gnt_a[i]), 32'(m_ga[i]));
            chk("gnt_b", i, 32'(gnt_b[i]), 32'(m_gb[i]));
            chk("gnt_excl", i, 32'(gnt_a[i] & gnt_b[i]), 32'd0);
            chk("disp_data", i, 32'(disp_data[i]), 32'(m_disp[i]));
            chk("disp_src", i, 32'(disp_src[i]), 32'(m_src[i]));
            chk("busy", i, 32'(busy[i]), 32'(m_left[i] > 0));
        end
    end

    int nb;
    int gcount;
    int gk [8];
    logic gwho [8];
    int exp_k [5] = '{1, 6, 11, 16, 21};
    logic exp_who [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1;
        req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_disp", 0, 32'(disp_data[0]), 32'h0000);
        chk("rst_src", 0, 32'(disp_src[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);

        // Single A request, hold of four cycles
        req_a[0] = 1'b1; data_a[0] = 16'h12AB;
        @(negedge clk);
        chk("l_gnt_a", 0, 32'(gnt_a[0]), 32'd1);
        chk("l_disp", 0, 32'(disp_data[0]), 32'h12AB);
        chk("l_src", 0, 32'(disp_src[0]), 32'd1);
        chk("l_busy2", 0, 32'(busy[0]), 32'd1);
        req_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("l_busy5", 0, 32'(busy[0]), 32'd1);
        chk("l_gnt_a_off", 0, 32'(gnt_a[0]), 32'd0);
        @(negedge clk);
        chk("l_busy6", 0, 32'(busy[0]), 32'd0);

        // B request raised and dropped while busy is ignored
        req_a[0] = 1'b1; data_a[0] = 16'h3333;
        @(negedge clk);
        req_a[0] = 1'b0;
        req_b[0] = 1'b1; data_b[0] = 16'h5555;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) req_b[0] = 1'b0;
            nb += int'(gnt_b[0]);
        end
        chk("l_no_gnt_b", 0, 32'(nb), 32'd0);
        chk("l_disp_kept", 0, 32'(disp_data[0]), 32'h3333);

        // Asynchronous reset in the middle of a hold
        req_a[0] = 1'b1; data_a[0] = 16'h7777;
        @(negedge clk);
        req_a[0] = 1'b0;
        @(negedge clk);
        chk("l_pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("l_arst_disp", 0, 32'(disp_data[0]), 32'h0000);
        chk("l_arst_src", 0, 32'(disp_src[0]), 32'd0);
        chk("l_arst_busy", 0, 32'(busy[0]), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Continuous tie: alternate A,B,A,... every five cycles, starting A
        req_a[0] = 1'b1; req_b[0] = 1'b1;
        data_a[0] = 16'hAAAA; data_b[0] = 16'hBBBB;
        gcount = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if ((gnt_a[0] || gnt_b[0]) && gcount < 8) begin
                gk[gcount] = k; gwho[gcount] = gnt_b[0]; gcount++;
            end
        end
        req_a[0] = 1'b0; req_b[0] = 1'b0;
        chk("l_rr_count", 0, 32'(gcount), 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < gcount) begin
                chk("l_rr_cycle", j, 32'(gk[j]), 32'(exp_k[j]));
                chk("l_rr_who", j, 32'(gwho[j]), 32'(exp_who[j]));
            end
        end

        // HOLD_CYCLES = 1: B held high is granted every second cycle
        req_b[1] = 1'b1; data_b[1] = 16'h0100;
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nb += int'(gnt_b[1]);
            data_b[1] = data_b[1] + 16'h0001;
        end
        req_b[1] = 1'b0;
        chk("l_h1_gnt_b", 1, 32'(nb), 32'd5);
        chk("l_h1_src", 1, 32'(disp_src[1]), 32'd2);

        // Random traffic on both instances
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                req_a[i]  = ($urandom_range(0, 1) == 1);
                req_b[i]  = ($urandom_range(0, 1) == 1);
                data_a[i] = 16'($urandom);
                data_b[i] = 16'($urandom);
            end
        end
        req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
